tile_lane_renderer: RTL and testbench

Multi-lane falling-tile renderer for the 160x120 VGA adapter path. Each lane holds at most one rectangular tile that descends STEP rows per frame tick. On every tick the block sweeps the active lanes and performs only the incremental pixel work: it erases the tile's vacated top rows and paints its new bottom rows. All pixel writes go through one serialized plot/x/y/colour port, so no external priority mux is needed.

---
 rtl/tile_lane_renderer_pkg.sv | 22 ++
 rtl/tile_lane_renderer_rect_scan.sv | 64 ++++++
 rtl/tile_lane_renderer.sv | 211 +++++++++++++++++++++
 tb/tb_tile_lane_renderer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_lane_renderer_pkg.sv
// Shared FSM codes, erase colour default and lane geometry helper
// for tile_lane_renderer (optional HIT_EN kill path lives in the top).
package tile_lane_renderer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PEND  = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_ADV   = 3'd5;

  localparam logic [2:0] BG_DEFAULT = 3'b000;

  function automatic int lane_x(
    input int lane,
    input int x0,
    input int pitch
  );
    return x0 + lane * pitch;
  endfunction

endpackage

// File: rtl/tile_lane_renderer_rect_scan.sv
// Row/column rectangle scanner, one pixel per cycle, column-fastest,
// with vertical clipping; shared by the erase and draw phases.
module rect_scan #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int YS       = 10,
  parameter int TILE_W   = 30,
  parameter int SCREEN_H = 120
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic [X_W-1:0]       i_x0,
  input  logic signed [YS-1:0] i_y0,
  input  logic [5:0]           i_nrows,
  output logic                 o_vis,
  output logic [X_W-1:0]       o_x,
  output logic [Y_W-1:0]       o_y,
  output logic                 o_done
);

  localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam logic signed [YS-1:0] SH_V = YS'(SCREEN_H);

  logic                 r_run;
  logic [CW-1:0]        r_col;
  logic [5:0]           r_left;
  logic signed [YS-1:0] r_row;
  logic [X_W-1:0]       r_x0;
  logic                 w_last_col;

  assign w_last_col = (r_col == CW'(TILE_W - 1));
  assign o_done = r_run && w_last_col && (r_left == 6'd1);
  assign o_vis = r_run && !r_row[YS-1] && (r_row < SH_V);
  assign o_x = r_x0 + X_W'(r_col);
  assign o_y = r_row[Y_W-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_run  <= 1'b0;
      r_col  <= '0;
      r_left <= '0;
      r_row  <= '0;
      r_x0   <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_col  <= '0;
      r_left <= i_nrows;
      r_row  <= i_y0;
      r_x0   <= i_x0;
    end else if (r_run) begin
      if (w_last_col) begin
        r_col  <= '0;
        r_row  <= r_row + 1'b1;
        r_left <= r_left - 1'b1;
        if (r_left == 6'd1)
          r_run <= 1'b0;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_lane_renderer.sv
// Falling-tile lane renderer: per-frame incremental erase/draw sweep.
// Define HIT_EN to add hit/hit_ok and the full-tile kill erase.
module tile_lane_renderer
  import tile_lane_renderer_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int SCREEN_H   = 120,
  parameter int TILE_W     = 30,
  parameter int TILE_H     = 30,
  parameter int STEP       = 1,
  parameter int LANE_X0    = 19,
  parameter int LANE_PITCH = 31,
  parameter logic [2:0] BG_COLOUR = BG_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic [N_LANES-1:0] spawn_req,
  input  logic [2:0]         tile_colour,
`ifdef HIT_EN
  input  logic [N_LANES-1:0] hit,
  output logic [N_LANES-1:0] hit_ok,
`endif
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [2:0]         colour,
  output logic               busy,
  output logic [N_LANES-1:0] active,
  output logic [N_LANES-1:0] miss,
  output logic               overrun
);

  localparam int PW = $clog2(SCREEN_H + TILE_H + 1);
  localparam int YS = PW + 2;
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [PW:0] STEP_V = (PW+1)'(STEP);
  localparam logic [PW:0] END_V = (PW+1)'(SCREEN_H + TILE_H);

  logic [2:0]         r_state;
  logic [LW-1:0]      r_lane;
  logic [N_LANES-1:0] r_active;
  logic [N_LANES-1:0] r_miss;
  logic [PW-1:0]      r_pos [N_LANES];
  logic               r_pend;
  logic               r_overrun;
  logic               r_killing;
  logic               r_plot;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [2:0]         r_colour;

  logic [N_LANES-1:0] w_act;
  logic               w_last;
  logic [PW-1:0]      w_pos_sel;
  logic [PW:0]        w_pos_nx;
  logic               w_kill_sel;
  logic               w_start;
  logic signed [YS-1:0] w_y0;
  logic [5:0]         w_n;
  logic [X_W-1:0]     w_x0;
  logic               w_vis;
  logic [X_W-1:0]     w_sx;
  logic [Y_W-1:0]     w_sy;
  logic               w_done;

  // a spawn landing in this lane's select slot is served this sweep
  assign w_act = r_active | spawn_req;
  assign w_last = (r_lane == LW'(N_LANES - 1));
  assign w_pos_sel = r_active[r_lane] ? r_pos[r_lane] : '0;
  assign w_pos_nx = {1'b0, r_pos[r_lane]} + STEP_V;
  assign w_x0 = X_W'(lane_x(int'(r_lane), LANE_X0, LANE_PITCH));

  assign w_start = ((r_state == S_SEL) && w_act[r_lane])
                || ((r_state == S_ERASE) && w_done && !r_killing);
  assign w_y0 = (r_state == S_SEL)
              ? YS'(w_pos_sel) - YS'(TILE_H)
              : YS'(r_pos[r_lane]);
  assign w_n = ((r_state == S_SEL) && w_kill_sel)
             ? 6'(TILE_H) : 6'(STEP);

  rect_scan #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .YS       (YS),
    .TILE_W   (TILE_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .i_start (w_start),
    .i_x0    (w_x0),
    .i_y0    (w_y0),
    .i_nrows (w_n),
    .o_vis   (w_vis),
    .o_x     (w_sx),
    .o_y     (w_sy),
    .o_done  (w_done)
  );

`ifdef HIT_EN
  logic [N_LANES-1:0] r_kill;
  logic [N_LANES-1:0] r_hit_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_kill   <= '0;
      r_hit_ok <= '0;
    end else begin
      r_hit_ok <= '0;
      for (int i = 0; i < N_LANES; i++)
        if (hit[i] && r_active[i]
            && int'(r_pos[i]) >= SCREEN_H - TILE_H / 2
            && int'(r_pos[i]) <= SCREEN_H + TILE_H / 2)
          r_kill[i] <= 1'b1;
      if ((r_state == S_ADV) && r_killing) begin
        r_kill[r_lane]   <= 1'b0;
        r_hit_ok[r_lane] <= 1'b1;
      end
    end
  end

  assign w_kill_sel = r_kill[r_lane];
  assign hit_ok = r_hit_ok;
`else
  assign w_kill_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_active  <= '0;
      r_miss    <= '0;
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
      r_killing <= 1'b0;
      r_plot    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      for (int i = 0; i < N_LANES; i++)
        r_pos[i] <= '0;
    end else begin
      r_miss   <= '0;
      r_plot   <= w_vis;
      r_x      <= w_sx;
      r_y      <= w_sy;
      r_colour <= (r_state == S_ERASE) ? BG_COLOUR : tile_colour;
      for (int i = 0; i < N_LANES; i++)
        if (spawn_req[i] && !r_active[i]) begin
          r_active[i] <= 1'b1;
          r_pos[i]    <= '0;
        end
      if (r_state == S_IDLE) begin
        r_pend <= r_pend & frame_tick;
      end else if (frame_tick) begin
        r_pend <= 1'b1;
        if (r_pend)
          r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE:
          if (frame_tick || r_pend) begin
            r_state <= S_SEL;
            r_lane  <= '0;
          end
        S_SEL:
          if (w_act[r_lane]) begin
            r_state   <= S_ERASE;
            r_killing <= w_kill_sel;
          end else if (w_last) begin
            r_state <= S_IDLE;
          end else begin
            r_lane <= r_lane + 1'b1;
          end
        S_ERASE:
          if (w_done)
            r_state <= r_killing ? S_ADV : S_DRAW;
        S_DRAW:
          if (w_done)
            r_state <= S_ADV;
        S_ADV: begin
          r_pos[r_lane] <= w_pos_nx[PW-1:0];
          if (r_killing) begin
            r_active[r_lane] <= 1'b0;
          end else if (w_pos_nx >= END_V) begin
            r_active[r_lane] <= 1'b0;
            r_miss[r_lane]   <= 1'b1;
          end
          r_state <= w_last ? S_IDLE : S_SEL;
          if (!w_last)
            r_lane <= r_lane + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign plot    = r_plot;
  assign x       = r_x;
  assign y       = r_y;
  assign colour  = r_colour;
  assign busy    = (r_state != S_IDLE);
  assign active  = r_active;
  assign miss    = r_miss;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_tile_lane_renderer.sv
// Directed bench for tile_lane_renderer: STEP=1 and STEP=2 instances
// share stimulus; sweep vectors in a table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_tile_lane_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] spawn_req = 4'b0;
  logic [2:0] tile_colour = 3'b0;

  logic       plot, plot2;
  logic [7:0] x, x2;
  logic [6:0] y, y2;
  logic [2:0] colour, colour2;
  logic       busy, busy2;
  logic [3:0] active, active2, miss, miss2;
  logic       overrun, overrun2;

  always #5 clk = ~clk;

  tile_lane_renderer u_dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .spawn_req(spawn_req), .tile_colour(tile_colour),
    .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .active(active), .miss(miss),
    .overrun(overrun)
  );

  tile_lane_renderer #(.STEP(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .spawn_req(spawn_req), .tile_colour(tile_colour),
    .plot(plot2), .x(x2), .y(y2), .colour(colour2),
    .busy(busy2), .active(active2), .miss(miss2),
    .overrun(overrun2)
  );

  typedef struct {
    logic [3:0]  sp;
    logic [2:0]  col;
    int          b1, p1, mnx, mxx, mxy;
    logic [3:0]  act;
    int          b2, p2;
    logic [31:0] l2;
  } vec_t;

  vec_t vt [5];

  int total = 0;
  int bad = 0;
  int np1, np2, minx, maxx, maxy, colerr, ordererr, last2;
  int missc, bady, sweeps, lidx;
  int cnt2 [4];
  bit saw119, pb;

  task automatic clr();
    np1 = 0; np2 = 0; minx = 999; maxx = -1; maxy = -1;
    colerr = 0; ordererr = 0; last2 = 0; sweeps = 0;
    for (int i = 0; i < 4; i++) cnt2[i] = 0;
  endtask

  always @(negedge clk) begin
    if (plot) begin
      np1++;
      if (int'(x) < minx) minx = int'(x);
      if (int'(x) > maxx) maxx = int'(x);
      if (int'(y) > maxy) maxy = int'(y);
      if (colour != tile_colour) colerr++;
      if (y >= 7'd120) bady++;
      if (y == 7'd119 && colour == tile_colour) saw119 = 1'b1;
    end
    if (plot2) begin
      np2++;
      lidx = (int'(x2) - 19) / 31;
      if (int'(x2) < 19 || lidx > 3) ordererr++;
      else begin
        cnt2[lidx]++;
        if (lidx < last2) ordererr++;
        last2 = lidx;
      end
      if (colour2 != tile_colour) colerr++;
    end
    missc += int'(miss[0]);
    if (busy && !pb) sweeps++;
    pb = busy;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_spawn(input logic [3:0] m);
    @(negedge clk);
    spawn_req = m;
    @(negedge clk);
    spawn_req = 4'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle(output int b1, output int b2);
    int n;
    b1 = 0; b2 = 0; n = 0;
    while ((busy || busy2) && n < 3000) begin
      b1 += int'(busy);
      b2 += int'(busy2);
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL idle_timeout: got %0d cycles want <3000", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int b1, b2, n, quiet;
    vt[0] = '{sp:4'b0000, col:3'b000, b1:4, p1:0, mnx:999, mxx:-1,
              mxy:-1, act:4'b0000, b2:4, p2:0, l2:32'h0};
    vt[1] = '{sp:4'b0001, col:3'b101, b1:65, p1:30, mnx:19, mxx:48,
              mxy:0, act:4'b0001, b2:125, p2:60, l2:32'h0000003C};
    vt[2] = '{sp:4'b0000, col:3'b010, b1:65, p1:30, mnx:19, mxx:48,
              mxy:1, act:4'b0001, b2:125, p2:60, l2:32'h0000003C};
    vt[3] = '{sp:4'b0100, col:3'b111, b1:126, p1:60, mnx:19, mxx:110,
              mxy:2, act:4'b0101, b2:246, p2:120, l2:32'h003C003C};
    vt[4] = '{sp:4'b1010, col:3'b001, b1:248, p1:120, mnx:19, mxx:141,
              mxy:3, act:4'b1111, b2:488, p2:240, l2:32'h3C3C3C3C};

    pb = 1'b0; missc = 0; bady = 0; saw119 = 1'b0;
    clr();
    do_reset();
    chk("reset_outs",
        {plot, x, y, colour, busy, active, miss, overrun,
         plot2, x2, y2, colour2, busy2, active2, miss2, overrun2},
        64'h0);

    for (int i = 0; i < 5; i++) begin
      clr();
      tile_colour = vt[i].col;
      do_spawn(vt[i].sp);
      tick();
      wait_idle(b1, b2);
      chk($sformatf("v%0d_busy", i), b1, vt[i].b1);
      chk($sformatf("v%0d_plots", i), np1, vt[i].p1);
      chk($sformatf("v%0d_minx", i), minx, vt[i].mnx);
      chk($sformatf("v%0d_maxx", i), maxx, vt[i].mxx);
      chk($sformatf("v%0d_maxy", i), maxy, vt[i].mxy);
      chk($sformatf("v%0d_active", i), {active2, active},
          {vt[i].act, vt[i].act});
      chk($sformatf("v%0d_busy2", i), b2, vt[i].b2);
      chk($sformatf("v%0d_plots2", i), np2, vt[i].p2);
      chk($sformatf("v%0d_lanes2", i),
          {8'(cnt2[3]), 8'(cnt2[2]), 8'(cnt2[1]), 8'(cnt2[0])},
          vt[i].l2);
      chk($sformatf("v%0d_colour", i), colerr, 0);
      chk($sformatf("v%0d_order", i), ordererr, 0);
    end

    // lane 0 falls off the bottom after 150 frames
    do_reset();
    clr();
    missc = 0; bady = 0; saw119 = 1'b0;
    tile_colour = 3'b110;
    do_spawn(4'b0001);
    for (int k = 1; k <= 150; k++) begin
      tick();
      wait_idle(b1, b2);
      if (k == 149) chk("miss_before_150", missc, 0);
    end
    chk("miss_once", missc, 1);
    chk("miss_active0", active[0], 1'b0);
    chk("miss_saw_y119", saw119, 1'b1);
    chk("miss_no_offscreen", bady, 0);
    tick();
    wait_idle(b1, b2);
    chk("post_miss_busy", b1, 4);
    chk("post_miss_no_repeat", missc, 1);

    // two ticks during a busy sweep
    do_reset();
    clr();
    do_spawn(4'b0001);
    tick();
    repeat (10) @(negedge clk);
    chk("ovr_early", overrun, 1'b0);
    tick();
    repeat (5) @(negedge clk);
    tick();
    chk("ovr_set", overrun, 1'b1);
    n = 0; quiet = 0;
    while (quiet < 3 && n < 1000) begin
      if (busy) quiet = 0;
      else quiet++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL ovr_timeout: got %0d cycles want <1000", n);
    end
    chk("ovr_sweeps", sweeps, 2);
    chk("ovr_sticky", overrun, 1'b1);

    // reset in the middle of the draw phase
    do_reset();
    tile_colour = 3'b011;
    do_spawn(4'b0001);
    tick();
    n = 0;
    while (!plot && n < 500) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL draw_timeout: got %0d cycles want <500", n);
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_plot", plot, 1'b0);
    chk("rst_active", active, 4'b0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_quiet", {plot, busy, active}, 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
